ex_stage: RTL

Execute stage of the five-stage RV32I pipeline: the ID/EX pipeline register plus everything that consumes the decoded `ALUControl` word. It operates the forwarding muxes, the ALU source mux, the ALU, branch/jump resolution and the branch-target adder. It sits between the decode stage (controller and ALU decoder) and the EX/MEM register. It is the first stage that acts on the 3-bit ALU control code.

---
 rtl/ex_stage.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// Purpose: RV32I execute stage -- ID/EX register, forwarding muxes, ALU, branch/jump resolution, target adder.
// Latency: D inputs appear on E outputs one clk after capture; ALU/target/PCSrc are combinational from E regs.
// Backpressure: none; StallE holds the ID/EX register, FlushE loads a bubble (flush beats stall).
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            JumpD,
    input  logic            BranchD,
    input  logic            ALUSrcD,
    input  logic [1:0]      ResultSrcD,
    input  logic [2:0]      ALUControlD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] ResultW,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic [1:0]      ResultSrcE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [XLEN-1:0] ALUResultE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            ZeroE,
    output logic            PCSrcE
);

    // Control half of the ID/EX register. An all-zero value is a bubble:
    // no register write, no memory write, no branch, no jump.
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic [1:0] result_src;
        logic [2:0] alu_control;
    } ctrl_t;

    // Data half of the ID/EX register.
    typedef struct packed {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc_plus4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } data_t;

    // ALU operation codes as produced by the ALU decoder.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Forwarding select encoding from the hazard unit.
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    ctrl_t           ctrl_d;
    ctrl_t           ctrl_e;
    data_t           data_d;
    data_t           data_e;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b_fwd;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic            slt_bit;
    logic [XLEN-1:0] alu_res;

    // Gather decode-stage inputs into the register payload.
    always_comb begin
        ctrl_d             = '0;
        ctrl_d.reg_write   = RegWriteD;
        ctrl_d.mem_write   = MemWriteD;
        ctrl_d.jump        = JumpD;
        ctrl_d.branch      = BranchD;
        ctrl_d.alu_src     = ALUSrcD;
        ctrl_d.result_src  = ResultSrcD;
        ctrl_d.alu_control = ALUControlD;

        data_d             = '0;
        data_d.rd1         = RD1D;
        data_d.rd2         = RD2D;
        data_d.pc          = PCD;
        data_d.imm         = ImmExtD;
        data_d.pc_plus4    = PCPlus4D;
        data_d.rs1         = Rs1D;
        data_d.rs2         = Rs2D;
        data_d.rd          = RdD;
    end

    // ID/EX register: reset > flush (bubble) > stall (hold) > load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_e <= '0;
            data_e <= '0;
        end else if (FlushE) begin
            ctrl_e <= '0;
            data_e <= '0;
        end else if (!StallE) begin
            ctrl_e <= ctrl_d;
            data_e <= data_d;
        end
    end

    // Forwarding muxes; 11 falls back to the register-file operand.
    always_comb begin
        src_a = data_e.rd1;
        case (ForwardAE)
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = ALUResultM;
            default: src_a = data_e.rd1;
        endcase

        src_b_fwd = data_e.rd2;
        case (ForwardBE)
            FWD_WB:  src_b_fwd = ResultW;
            FWD_MEM: src_b_fwd = ALUResultM;
            default: src_b_fwd = data_e.rd2;
        endcase
    end

    // ALU source B: immediate or the forwarded rs2 value.
    always_comb begin
        src_b = ctrl_e.alu_src ? data_e.imm : src_b_fwd;
    end

    // ALU: modulo-2^XLEN add/sub, bitwise and/or, signed set-less-than.
    // slt looks at the sign bits directly when they differ so that a
    // wrapped subtraction never yields the wrong answer.
    always_comb begin
        sum  = src_a + src_b;
        diff = src_a - src_b;
        if (src_a[XLEN-1] != src_b[XLEN-1]) begin
            slt_bit = src_a[XLEN-1];
        end else begin
            slt_bit = diff[XLEN-1];
        end

        alu_res = '0;
        case (ctrl_e.alu_control)
            ALU_ADD: alu_res = sum;
            ALU_SUB: alu_res = diff;
            ALU_AND: alu_res = src_a & src_b;
            ALU_OR:  alu_res = src_a | src_b;
            ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, slt_bit};
            default: alu_res = '0;
        endcase
    end

    // Branch/jump resolution (beq only) and the branch-target adder.
    always_comb begin
        ALUResultE = alu_res;
        WriteDataE = src_b_fwd;
        ZeroE      = (alu_res == '0);
        PCSrcE     = (ctrl_e.branch & ZeroE) | ctrl_e.jump;
        PCTargetE  = data_e.pc + data_e.imm;
    end

    // Registered fields passed straight on to the next stage and hazard unit.
    always_comb begin
        RegWriteE  = ctrl_e.reg_write;
        MemWriteE  = ctrl_e.mem_write;
        ResultSrcE = ctrl_e.result_src;
        Rs1E       = data_e.rs1;
        Rs2E       = data_e.rs2;
        RdE        = data_e.rd;
        PCPlus4E   = data_e.pc_plus4;
    end

endmodule
